// File: rtl/ps2_teclado_rx.sv
// PS/2 keyboard receiver: syncs and filters ps2c/ps2d, deserialises 11-bit frames,
// strips E0/F0 prefixes and strobes one make code per key event.
// Ports: clk, reset (sync, active-high), ps2c/ps2d (async pins), rx_en (gates frame start),
//        key_code/key_ext (held last make code + extended flag), listo (code strobe),
//        err (parity/stop/timeout strobe).
module ps2_teclado_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] key_code,
    output logic       listo,
    output logic       key_ext,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAR,
        STOP,
        CHK
    } state_t;

    state_t state, state_n;

    logic [1:0]            c_sync, d_sync;
    logic [FILTER_LEN-1:0] filt;
    logic                  fclk, fclk_q;
    logic                  fall, data_s;
    logic [3:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  par_bit, stop_bit;
    logic                  brk, ext;
    logic [TW-1:0]         tmo;
    logic                  tmo_hit, timed_out, frame_ok;

    // Synchronisers and clock glitch filter; the filtered clock only
    // changes once FILTER_LEN consecutive samples agree.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            filt   <= '1;
            fclk   <= 1'b1;
            fclk_q <= 1'b1;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
            filt   <= {filt[FILTER_LEN-2:0], c_sync[1]};
            if (filt == '0)
                fclk <= 1'b0;
            else if (filt == '1)
                fclk <= 1'b1;
            fclk_q <= fclk;
        end
    end

    assign fall     = fclk_q & ~fclk;
    assign data_s   = d_sync[1];
    assign tmo_hit  = (tmo == TW'(TIMEOUT - 1));
    // Odd parity: data bits plus parity bit must xor to 1.
    assign frame_ok = (^{shreg, par_bit}) & stop_bit;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        timed_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall && rx_en && !data_s)
                    state_n = DATA;
            end
            DATA: begin
                if (fall) begin
                    if (bit_cnt == 4'd7)
                        state_n = PAR;
                end else if (tmo_hit) begin
                    state_n   = IDLE;
                    timed_out = 1'b1;
                end
            end
            PAR: begin
                if (fall) begin
                    state_n = STOP;
                end else if (tmo_hit) begin
                    state_n   = IDLE;
                    timed_out = 1'b1;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = CHK;
                end else if (tmo_hit) begin
                    state_n   = IDLE;
                    timed_out = 1'b1;
                end
            end
            CHK: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bit <= 1'b0;
            brk      <= 1'b0;
            ext      <= 1'b0;
            tmo      <= '0;
            key_code <= 8'h00;
            key_ext  <= 1'b0;
            listo    <= 1'b0;
            err      <= 1'b0;
        end else begin
            listo <= 1'b0;
            err   <= 1'b0;

            if (fall || state == IDLE || state == CHK)
                tmo <= '0;
            else
                tmo <= tmo + TW'(1);

            case (state)
                IDLE: begin
                    if (fall && rx_en && !data_s)
                        bit_cnt <= '0;
                end
                DATA: begin
                    if (fall) begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                PAR: begin
                    if (fall)
                        par_bit <= data_s;
                end
                STOP: begin
                    if (fall)
                        stop_bit <= data_s;
                end
                CHK: begin
                    if (!frame_ok) begin
                        err <= 1'b1;
                        brk <= 1'b0;
                        ext <= 1'b0;
                    end else if (shreg == 8'hE0) begin
                        ext <= 1'b1;
                    end else if (shreg == 8'hF0) begin
                        brk <= 1'b1;
                    end else if (brk) begin
                        // Break code of a released key: swallow it.
                        brk <= 1'b0;
                        ext <= 1'b0;
                    end else begin
                        key_code <= shreg;
                        key_ext  <= ext;
                        listo    <= 1'b1;
                        ext      <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (timed_out) begin
                err     <= 1'b1;
                brk     <= 1'b0;
                ext     <= 1'b0;
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// Scoreboard bench for ps2_teclado_rx: directed PS/2 frames, expected strobes
// queued by the stimulus and checked by an independent monitor.
module tb_ps2_teclado_rx;

    localparam int FL  = 8;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       rx_en = 1'b1;
    logic [7:0] key_code;
    logic       listo, key_ext, err;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic       ext;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    ps2_teclado_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .key_code(key_code), .listo(listo), .key_ext(key_ext), .err(err)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] code, input logic par_ok,
                                       input logic stop);
        logic p;
        p = par_ok ? ~^code : ^code;
        return {stop, p, code, 1'b0};
    endfunction

    task automatic send_range(input logic [10:0] bits, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ps2d = bits[i];
            wait_clk(10);
            ps2c = 1'b0;
            wait_clk(20);
            ps2c = 1'b1;
            wait_clk(10);
        end
        ps2d = 1'b1;
    endtask

    task automatic frame(input logic [7:0] code);
        send_range(mk(code, 1'b1, 1'b1), 0, 10);
        wait_clk(30);
    endtask

    task automatic push(input logic is_err, input logic [7:0] code, input logic ext);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.ext    = ext;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    logic prev_strobe = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (listo || err) begin
                n_vec++;
                if (listo && err) begin
                    n_bad++;
                    $display("FAIL both_strobes: listo=%b err=%b", listo, err);
                end else if (prev_strobe) begin
                    n_bad++;
                    $display("FAIL consecutive_strobe: listo=%b err=%b", listo, err);
                end else if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_strobe: listo=%b err=%b code=%h",
                             listo, err, key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (err !== e.is_err || key_code !== e.code ||
                        (!e.is_err && key_ext !== e.ext)) begin
                        n_bad++;
                        $display("FAIL strobe: got err=%b code=%h ext=%b expected err=%b code=%h ext=%b",
                                 err, key_code, key_ext, e.is_err, e.code, e.ext);
                    end
                end
            end
            prev_strobe = listo | err;
        end
    end

    initial begin
        logic [10:0] b;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(2);
        check("rst_key_code", key_code, 8'h00);
        check("rst_listo", {7'b0, listo}, 8'h00);
        check("rst_key_ext", {7'b0, key_ext}, 8'h00);
        check("rst_err", {7'b0, err}, 8'h00);

        push(1'b0, 8'h1D, 1'b0);
        frame(8'h1D);

        frame(8'hF0);
        frame(8'h1D);
        push(1'b0, 8'h1D, 1'b0);
        frame(8'h1D);

        frame(8'hE0);
        push(1'b0, 8'h75, 1'b1);
        frame(8'h75);
        frame(8'hE0);
        frame(8'hF0);
        frame(8'h75);
        push(1'b0, 8'h1C, 1'b0);
        frame(8'h1C);

        push(1'b1, 8'h1C, 1'b0);
        send_range(mk(8'h1D, 1'b0, 1'b1), 0, 10);
        wait_clk(30);
        push(1'b1, 8'h1C, 1'b0);
        send_range(mk(8'h1D, 1'b1, 1'b0), 0, 10);
        wait_clk(30);

        push(1'b1, 8'h1C, 1'b0);
        send_range(mk(8'h2B, 1'b1, 1'b1), 0, 4);
        wait_clk(TMO + 50);
        push(1'b0, 8'h2B, 1'b0);
        frame(8'h2B);

        b = mk(8'h5A, 1'b1, 1'b1);
        push(1'b0, 8'h5A, 1'b0);
        send_range(b, 0, 3);
        ps2c = 1'b0;
        wait_clk(FL - 1);
        ps2c = 1'b1;
        wait_clk(20);
        send_range(b, 4, 10);
        wait_clk(30);

        send_range(mk(8'h11, 1'b1, 1'b1), 0, 3);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
        check("mid_reset_key_code", key_code, 8'h00);
        push(1'b0, 8'h23, 1'b0);
        frame(8'h23);

        wait_clk(100);
        check("queue_left", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
